// File: rtl/if_fetch_stage_pkg.sv
// Shared types for the instruction-fetch stage: IF/ID register layout, fetch FSM states,
// bubble instruction and PC increment helper.
package if_fetch_stage_pkg;

  localparam int unsigned PC_W = 9;
  localparam logic [31:0] NOP_INSTR = 32'h00000013;

  typedef struct packed {
    logic [PC_W-1:0] Curr_Pc;
    logic [31:0]     Curr_Instr;
  } if_id_reg;

  typedef enum logic [1:0] {
    F_IDLE,
    F_WAIT,
    F_DROP
  } fetch_state_e;

  // PC arithmetic wraps modulo 2^PC_W by construction
  function automatic logic [PC_W-1:0] pc_next(input logic [PC_W-1:0] pc);
    return pc + PC_W'(4);
  endfunction

endpackage

// File: rtl/if_fetch_stage_if.sv
// Instruction-memory request/ack bus; signal suffixes are from the fetch stage's point of view.
interface if_fetch_stage_if
  import if_fetch_stage_pkg::*;
();

  logic            imem_req_o;
  logic [PC_W-1:0] imem_addr_o;
  logic            imem_ack_i;
  logic [31:0]     imem_rdata_i;

  modport master (output imem_req_o, imem_addr_o, input imem_ack_i, imem_rdata_i);
  modport slave  (input imem_req_o, imem_addr_o, output imem_ack_i, imem_rdata_i);

endinterface

// File: rtl/if_fetch_buf.sv
// Prefetch FIFO of fetched {pc, instr} entries; clear wins over push, push+pop allowed when full.
module if_fetch_buf
  import if_fetch_stage_pkg::*;
#(
  parameter  int unsigned DEPTH = 2,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear_i,
  input  logic             push_i,
  input  if_id_reg         push_data_i,
  input  logic             pop_i,
  output if_id_reg         head_o,
  output logic [CNT_W-1:0] count_o,
  output logic             empty_o,
  output logic             full_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  if_id_reg         mem_q [DEPTH];
  logic [PTR_W-1:0] rd_q, wr_q;
  logic [CNT_W-1:0] cnt_q;
  logic             do_push, do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_comb begin
    do_pop  = pop_i && (cnt_q != '0);
    do_push = push_i && ((cnt_q < CNT_W'(DEPTH)) || do_pop);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else if (clear_i) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= ptr_inc(wr_q);
      if (do_pop)  rd_q <= ptr_inc(rd_q);
      cnt_q <= cnt_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !clear_i) mem_q[wr_q] <= push_data_i;
  end

  assign head_o  = mem_q[rd_q];
  assign count_o = cnt_q;
  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CNT_W'(DEPTH));

endmodule

// File: rtl/if_fetch_stage.sv
// RISC-V instruction-fetch stage: owns the PC, single-outstanding imem reads, prefetch buffer,
// IF/ID register with stall/flush. Optional perf counters enabled by `define IF_PERF_CNT_EN.
module if_fetch_stage
  import if_fetch_stage_pkg::*;
#(
  parameter int unsigned     BUF_DEPTH = 2,
  parameter logic [PC_W-1:0] RESET_PC  = '0,
  parameter logic [31:0]     NOP_INSTR = if_fetch_stage_pkg::NOP_INSTR
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    stall_i,
  input  logic                    flush_i,
  input  logic [PC_W-1:0]         redirect_pc_i,
  if_fetch_stage_if.master        imem,
  output if_id_reg                if_id_o,
  output logic                    if_id_valid_o
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0]             perf_fetch_cnt_o,
  output logic [31:0]             perf_stall_cnt_o
`endif
);

  localparam int unsigned CNT_W  = $clog2(BUF_DEPTH + 1);
  localparam if_id_reg    BUBBLE = '{Curr_Pc: '0, Curr_Instr: NOP_INSTR};

  fetch_state_e     state_q;
  logic [PC_W-1:0]  pc_q;
  logic             req_q;
  if_id_reg         if_id_q;
  logic             valid_q;

  if_id_reg         buf_head;
  logic [CNT_W-1:0] buf_cnt;
  logic             buf_empty, buf_full;
  logic             pop, push, keep_req;
  logic [CNT_W:0]   cnt_after;

  always_comb begin
    pop       = !stall_i && !flush_i && !buf_empty;
    push      = (state_q == F_WAIT) && imem.imem_ack_i && !flush_i;
    // occupancy once this cycle's pop and push both land; another request only if a slot remains
    cnt_after = {1'b0, buf_cnt} + (CNT_W + 1)'(1) - (CNT_W + 1)'(pop);
    keep_req  = cnt_after < (CNT_W + 1)'(BUF_DEPTH);
  end

  if_fetch_buf #(
    .DEPTH (BUF_DEPTH)
  ) u_buf (
    .clk         (clk),
    .reset       (reset),
    .clear_i     (flush_i),
    .push_i      (push),
    .push_data_i ('{Curr_Pc: pc_q, Curr_Instr: imem.imem_rdata_i}),
    .pop_i       (pop),
    .head_o      (buf_head),
    .count_o     (buf_cnt),
    .empty_o     (buf_empty),
    .full_o      (buf_full)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= F_IDLE;
      pc_q    <= RESET_PC;
      req_q   <= 1'b0;
    end else begin
      unique case (state_q)
        F_IDLE: begin
          if (!flush_i && !buf_full) begin
            state_q <= F_WAIT;
            req_q   <= 1'b1;
          end
        end
        F_WAIT: begin
          if (imem.imem_ack_i) begin
            if (flush_i || !keep_req) begin
              state_q <= F_IDLE;
              req_q   <= 1'b0;
            end
          end else if (flush_i) begin
            state_q <= F_DROP;
            req_q   <= 1'b0;
          end
        end
        F_DROP: begin
          if (imem.imem_ack_i) state_q <= F_IDLE;
        end
        default: begin
          state_q <= F_IDLE;
          req_q   <= 1'b0;
        end
      endcase
      if (flush_i)   pc_q <= redirect_pc_i;
      else if (push) pc_q <= pc_next(pc_q);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      if_id_q <= BUBBLE;
      valid_q <= 1'b0;
    end else if (flush_i) begin
      if_id_q <= BUBBLE;
      valid_q <= 1'b0;
    end else if (!stall_i) begin
      if_id_q <= buf_empty ? BUBBLE : buf_head;
      valid_q <= !buf_empty;
    end
  end

  assign imem.imem_req_o  = req_q;
  assign imem.imem_addr_o = pc_q;
  assign if_id_o          = if_id_q;
  assign if_id_valid_o    = valid_q;

`ifdef IF_PERF_CNT_EN
  logic [31:0] fetch_cnt_q, stall_cnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (pop)                 fetch_cnt_q <= fetch_cnt_q + 32'd1;
      if (stall_i && !flush_i) stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign perf_fetch_cnt_o = fetch_cnt_q;
  assign perf_stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// Randomised bench for if_fetch_stage with an in-bench queue model of the fetch stage and a
// variable-latency instruction-memory responder.
module tb_if_fetch_stage;
  import if_fetch_stage_pkg::*;

  localparam int unsigned     DEPTH  = 2;
  localparam logic [PC_W-1:0] RST_PC = '0;
  localparam if_id_reg        BUB    = '{Curr_Pc: '0, Curr_Instr: 32'h00000013};

  logic            clk   = 1'b0;
  logic            reset = 1'b1;
  logic            stall_i = 1'b0;
  logic            flush_i = 1'b0;
  logic [PC_W-1:0] redirect_pc_i = '0;
  if_id_reg        if_id;
  logic            if_id_valid;
`ifdef IF_PERF_CNT_EN
  logic [31:0]     perf_fetch, perf_stall;
`endif

  if_fetch_stage_if bus ();

  always #5 clk = ~clk;

  if_fetch_stage #(
    .BUF_DEPTH (DEPTH),
    .RESET_PC  (RST_PC),
    .NOP_INSTR (32'h00000013)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .stall_i       (stall_i),
    .flush_i       (flush_i),
    .redirect_pc_i (redirect_pc_i),
    .imem          (bus.master),
    .if_id_o       (if_id),
    .if_id_valid_o (if_id_valid)
`ifdef IF_PERF_CNT_EN
    ,
    .perf_fetch_cnt_o (perf_fetch),
    .perf_stall_cnt_o (perf_stall)
`endif
  );

  // behavioural model: PC stream, FIFO of fetched words, IF/ID contents
  if_id_reg        mq[$];
  if_id_reg        m_ifid = BUB;
  logic            m_valid = 1'b0;
  logic [PC_W-1:0] m_pc = RST_PC;
  logic            m_drop = 1'b0;
  logic [31:0]     m_fetch = '0, m_stall = '0;

  // memory responder
  logic pend = 1'b0;
  int   cnt = 0;
  int   lat_lo = 1, lat_hi = 1;

  int       n_vec = 0, n_bad = 0, cyc = 0, idle_run = 0;
  int       first_ack = -1, first_valid = -1;
  if_id_reg vlog[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic model_edge(input logic st, input logic fl, input logic [PC_W-1:0] rd,
                            input logic ack, input logic [31:0] rdata);
    if (!reset) begin
      mq.delete();
      m_ifid = BUB; m_valid = 1'b0; m_pc = RST_PC;
      m_drop = pend; m_fetch = '0; m_stall = '0;
      return;
    end
    if (st && !fl) m_stall++;
    if (fl) begin
      mq.delete();
      m_ifid = BUB; m_valid = 1'b0;
    end else if (!st) begin
      if (mq.size() > 0) begin
        m_ifid = mq.pop_front(); m_valid = 1'b1; m_fetch++;
      end else begin
        m_ifid = BUB; m_valid = 1'b0;
      end
    end
    if (ack) begin
      if (m_drop) m_drop = 1'b0;
      else if (!fl) begin
        mq.push_back('{Curr_Pc: m_pc, Curr_Instr: rdata});
        m_pc = m_pc + PC_W'(4);
        if (mq.size() > DEPTH) begin
          chk("buf_overflow", 64'(mq.size()), 64'(DEPTH));
          void'(mq.pop_back());
        end
      end
    end else if (fl && pend) m_drop = 1'b1;
    if (fl) m_pc = rd;
  endtask

  task automatic compare(input logic st, input logic fl);
    chk("if_id", if_id, m_ifid);
    chk("if_id_valid", if_id_valid, m_valid);
`ifdef IF_PERF_CNT_EN
    chk("perf_fetch", perf_fetch, m_fetch);
    chk("perf_stall", perf_stall, m_stall);
`endif
    if (!reset) begin
      chk("reset_req", bus.imem_req_o, 1'b0);
      chk("reset_addr", bus.imem_addr_o, RST_PC);
      return;
    end
    if (bus.imem_req_o) chk("imem_addr", bus.imem_addr_o, m_pc);
    if (m_drop || mq.size() >= DEPTH) chk("req_blocked", bus.imem_req_o, 1'b0);
    if (!fl && !m_drop && mq.size() < DEPTH && !bus.imem_req_o) idle_run++;
    else idle_run = 0;
    if (idle_run > 2) begin
      chk("req_liveness", bus.imem_req_o, 1'b1);
      idle_run = 0;
    end
    if (if_id_valid && !st && !fl) vlog.push_back(if_id);
    if (if_id_valid && first_valid < 0) first_valid = cyc;
  endtask

  task automatic respond();
    if (bus.imem_ack_i) begin
      bus.imem_ack_i = 1'b0;
      pend = 1'b0;
    end
    if (reset) begin
      if (!pend && bus.imem_req_o) begin
        pend = 1'b1;
        cnt  = $urandom_range(lat_hi, lat_lo);
      end
      if (pend) begin
        cnt--;
        if (cnt == 0) begin
          bus.imem_ack_i   = 1'b1;
          bus.imem_rdata_i = $urandom;
          if (first_ack < 0) first_ack = cyc + 1;
        end
      end
    end
  endtask

  task automatic step(input logic st, input logic fl, input logic [PC_W-1:0] rd);
    stall_i = st; flush_i = fl; redirect_pc_i = rd;
    @(posedge clk);
    cyc++;
    model_edge(st, fl, rd, bus.imem_ack_i, bus.imem_rdata_i);
    #1;
    compare(st, fl);
    respond();
  endtask

  initial begin
    int n;
    int base;
    bus.imem_ack_i   = 1'b0;
    bus.imem_rdata_i = '0;
    #1 reset = 1'b0;
    #1;
    chk("rst_if_id", if_id, BUB);
    chk("rst_valid", if_id_valid, 1'b0);
    chk("rst_req", bus.imem_req_o, 1'b0);
    chk("rst_addr", bus.imem_addr_o, RST_PC);
    step(1'b0, 1'b0, '0);
    reset = 1'b1;

    // 1: latency 1, no stall
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, '0);
    chk("t1_latency", 64'(first_valid), 64'(first_ack + 1));
    chk("t1_count", 64'(vlog.size()), 64'd4);
    chk("t1_pc0", vlog[0].Curr_Pc, 9'h000);
    chk("t1_pc1", vlog[1].Curr_Pc, 9'h004);
    chk("t1_pc2", vlog[2].Curr_Pc, 9'h008);

    // 2: stall for 4 cycles with a 2-entry buffer
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b0, '0);
      chk("t2_frozen_pc", if_id.Curr_Pc, 9'h00C);
      chk("t2_frozen_valid", if_id_valid, 1'b1);
    end
    chk("t2_req_full", bus.imem_req_o, 1'b0);
    chk("t2_model_buffered", 64'(mq.size()), 64'd2);
    step(1'b0, 1'b0, '0);
    chk("t2_rel1", if_id.Curr_Pc, 9'h010);
    step(1'b0, 1'b0, '0);
    chk("t2_rel2", if_id.Curr_Pc, 9'h014);
    step(1'b0, 1'b0, '0);
    step(1'b0, 1'b0, '0);
    chk("t2_total", 64'(vlog.size()), 64'd7);
    chk("t2_next", vlog[6].Curr_Pc, 9'h018);

    // 3: flush during F_WAIT, ack three cycles later is dropped
    lat_lo = 3; lat_hi = 3;
    n = 0;
    while (!(pend && cnt == 2 && !m_drop) && n < 20) begin step(1'b0, 1'b0, '0); n++; end
    if (n >= 20) chk("t3_timeout", 1'b0, 1'b1);
    step(1'b0, 1'b1, 9'h040);
    n = 0;
    while (!if_id_valid && n < 30) begin step(1'b0, 1'b0, '0); n++; end
    chk("t3_first_valid", if_id_valid, 1'b1);
    chk("t3_pc", if_id.Curr_Pc, 9'h040);

    // 4: flush and ack in the same cycle while stalled
    lat_lo = 2; lat_hi = 2;
    n = 0;
    while (!(pend && bus.imem_ack_i && !m_drop) && n < 20) begin step(1'b0, 1'b0, '0); n++; end
    if (n >= 20) chk("t4_timeout", 1'b0, 1'b1);
    step(1'b1, 1'b1, 9'h0A0);
    chk("t4_if_id", if_id, BUB);
    chk("t4_valid", if_id_valid, 1'b0);
    chk("t4_model_empty", 64'(mq.size()), 64'd0);
    n = 0;
    while (!bus.imem_req_o && n < 10) begin step(1'b0, 1'b0, '0); n++; end
    chk("t4_req", bus.imem_req_o, 1'b1);
    chk("t4_addr", bus.imem_addr_o, 9'h0A0);

    // 5: PC wrap at the top of the address space
    lat_lo = 1; lat_hi = 1;
    step(1'b0, 1'b1, 9'h1F8);
    base = vlog.size();
    n = 0;
    while (vlog.size() < base + 3 && n < 30) begin step(1'b0, 1'b0, '0); n++; end
    chk("t5_count", 64'(vlog.size() >= base + 3), 64'd1);
    chk("t5_pc0", vlog[base].Curr_Pc, 9'h1F8);
    chk("t5_pc1", vlog[base+1].Curr_Pc, 9'h1FC);
    chk("t5_pc2", vlog[base+2].Curr_Pc, 9'h000);

    // 6: reset while a request is outstanding, ack arrives after release
    lat_lo = 4; lat_hi = 4;
    n = 0;
    while (!(pend && cnt == 3 && !m_drop) && n < 20) begin step(1'b0, 1'b0, '0); n++; end
    if (n >= 20) chk("t6_timeout", 1'b0, 1'b1);
    #2 reset = 1'b0;
    #1;
    chk("t6_async_req", bus.imem_req_o, 1'b0);
    chk("t6_async_if_id", if_id, BUB);
    chk("t6_async_valid", if_id_valid, 1'b0);
`ifdef IF_PERF_CNT_EN
    chk("t6_perf_fetch", perf_fetch, 32'd0);
    chk("t6_perf_stall", perf_stall, 32'd0);
`endif
    step(1'b0, 1'b0, '0);
    reset = 1'b1;
    bus.imem_ack_i   = 1'b1;
    bus.imem_rdata_i = $urandom;
    base = vlog.size();
    lat_lo = 1; lat_hi = 3;
    n = 0;
    while (vlog.size() <= base && n < 30) begin step(1'b0, 1'b0, '0); n++; end
    chk("t6_restart_seen", 64'(vlog.size() > base), 64'd1);
    chk("t6_restart_pc", vlog[base].Curr_Pc, RST_PC);

    // random traffic
    lat_lo = 1; lat_hi = 4;
    for (int i = 0; i < 800; i++) begin
      logic [PC_W-1:0] r;
      r = PC_W'($urandom) & 9'h1FC;
      step(($urandom_range(9, 0) < 3), ($urandom_range(19, 0) == 0), r);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
